// File: rtl/pipe_trace_buffer_pkg.sv
// Shared definitions for the pipeline trace buffer.
//   state_e      capture/readout FSM states
//   trig_mode_e  trigger source selection (matches the 2-bit trig_mode port)
//   entry_width  packed entry width for a given PC/data width:
//                {Stall_flush, WB_RegWrite, WB_WriteRegister[4:0], PC, WB_WriteData}
package pipe_trace_buffer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_POST,
      ST_DONE,
      ST_READOUT
   } state_e;

   typedef enum logic [1:0] {
      TRIG_IMM   = 2'd0,
      TRIG_PC    = 2'd1,
      TRIG_WREG  = 2'd2,
      TRIG_STALL = 2'd3
   } trig_mode_e;

   localparam int unsigned WREG_W = 5;

   function automatic int unsigned entry_width(input int unsigned data_w);
      return 2 * data_w + WREG_W + 2;
   endfunction

endpackage

// File: rtl/pipe_trace_buffer_trace_ram.sv
// Trace storage: DEPTH x WIDTH, one write port, one synchronous read port.
//   clk_i    rising-edge clock
//   we_i     write enable, waddr_i/wdata_i written on the edge
//   re_i     read enable; rdata_o updates only when set, otherwise holds
//   raddr_i  read address
//   rdata_o  registered read data
// The array carries no reset.
module trace_ram #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 71
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/pipe_trace_buffer.sv
// Pipeline trace buffer: records WB/PC state per qualified cycle into a
// circular buffer, stops a programmable number of samples after a trigger,
// then streams the capture out oldest-first over a valid/ready port.
//   clk, reset               clock, async active-high reset
//   arm, abort, start_read   control pulses
//   sample_en, PC_in, WB_*, Stall_flush   sample inputs
//   trig_mode, trig_value    trigger selection / compare value
//   post_count               samples kept after trigger (clamped to DEPTH-1)
//   rd_ready/rd_valid/rd_data/rd_last     readout stream
//   armed, triggered, done, trig_pos      status
module pipe_trace_buffer
   import pipe_trace_buffer_pkg::*;
#(
   parameter  int unsigned DEPTH   = 16,
   parameter  int unsigned DATA_W  = 32,
   localparam int unsigned AW      = $clog2(DEPTH),
   localparam int unsigned ENTRY_W = entry_width(DATA_W)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               arm,
   input  logic               abort,
   input  logic               sample_en,
   input  logic [DATA_W-1:0]  PC_in,
   input  logic               WB_RegWrite,
   input  logic [4:0]         WB_WriteRegister,
   input  logic [DATA_W-1:0]  WB_WriteData,
   input  logic               Stall_flush,
   input  logic [1:0]         trig_mode,
   input  logic [DATA_W-1:0]  trig_value,
   input  logic [AW:0]        post_count,
   input  logic               start_read,
   input  logic               rd_ready,
   output logic               rd_valid,
   output logic [ENTRY_W-1:0] rd_data,
   output logic               rd_last,
   output logic               armed,
   output logic               triggered,
   output logic               done,
   output logic [AW-1:0]      trig_pos
);

   localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
   localparam logic [AW:0] MAX_POST = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] ONE      = (AW+1)'(1);

   state_e          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]     fill_q, fill_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     rd_cnt_q, rd_cnt_d;
   logic [AW-1:0]   remain_q, remain_d;
   logic [AW-1:0]   trig_pos_q, trig_pos_d;
   logic            rd_valid_q, rd_valid_d;

   logic               we, re;
   logic [AW-1:0]      raddr, start_ptr;
   logic [ENTRY_W-1:0] entry_wdata, ram_rdata;
   logic [AW:0]        pc_clamped, trig_room, trig_idx, fill_inc;
   logic               trig_hit;

   assign entry_wdata = {Stall_flush, WB_RegWrite, WB_WriteRegister, PC_in, WB_WriteData};
   assign pc_clamped  = (post_count > MAX_POST) ? MAX_POST : post_count;
   // Trigger index in readout order: entries before it, capped by how many
   // older entries survive once the post-trigger samples have been written.
   assign trig_room   = MAX_POST - pc_clamped;
   assign trig_idx    = (fill_q < trig_room) ? fill_q : trig_room;
   assign fill_inc    = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
   assign start_ptr   = (fill_q == FULL) ? wr_ptr_q : '0;

   always_comb begin
      trig_hit = 1'b0;
      unique case (trig_mode_e'(trig_mode))
         TRIG_IMM:   trig_hit = 1'b1;
         TRIG_PC:    trig_hit = (PC_in == trig_value);
         TRIG_WREG:  trig_hit = WB_RegWrite && (WB_WriteRegister == trig_value[4:0]);
         TRIG_STALL: trig_hit = Stall_flush;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      fill_d     = fill_q;
      rd_ptr_d   = rd_ptr_q;
      rd_cnt_d   = rd_cnt_q;
      remain_d   = remain_q;
      trig_pos_d = trig_pos_q;
      rd_valid_d = rd_valid_q;
      we         = 1'b0;
      re         = 1'b0;
      raddr      = rd_ptr_q;

      if (abort) begin
         state_d    = ST_IDLE;
         rd_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (arm) begin
                  state_d  = ST_ARMED;
                  wr_ptr_d = '0;
                  fill_d   = '0;
               end
            end
            ST_ARMED: begin
               if (sample_en) begin
                  we       = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  fill_d   = fill_inc;
                  if (trig_hit) begin
                     trig_pos_d = trig_idx[AW-1:0];
                     remain_d   = pc_clamped[AW-1:0];
                     state_d    = (pc_clamped == '0) ? ST_DONE : ST_POST;
                  end
               end
            end
            ST_POST: begin
               if (sample_en) begin
                  we       = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  fill_d   = fill_inc;
                  remain_d = remain_q - 1'b1;
                  if (remain_q == ONE[AW-1:0]) state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               if (arm) begin
                  state_d  = ST_ARMED;
                  wr_ptr_d = '0;
                  fill_d   = '0;
               end else if (start_read) begin
                  // Issue the first read now so data is valid next cycle.
                  state_d    = ST_READOUT;
                  rd_ptr_d   = start_ptr;
                  rd_cnt_d   = fill_q;
                  raddr      = start_ptr;
                  re         = 1'b1;
                  rd_valid_d = 1'b1;
               end
            end
            ST_READOUT: begin
               // rd_ptr_q addresses the entry currently presented; the RAM
               // read register holds it until the next transfer.
               if (rd_valid_q && rd_ready) begin
                  if (rd_cnt_q == ONE) begin
                     state_d    = ST_IDLE;
                     rd_valid_d = 1'b0;
                  end else begin
                     rd_ptr_d = rd_ptr_q + 1'b1;
                     raddr    = rd_ptr_q + 1'b1;
                     re       = 1'b1;
                     rd_cnt_d = rd_cnt_q - 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         fill_q     <= '0;
         rd_ptr_q   <= '0;
         rd_cnt_q   <= '0;
         remain_q   <= '0;
         trig_pos_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         fill_q     <= fill_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_cnt_q   <= rd_cnt_d;
         remain_q   <= remain_d;
         trig_pos_q <= trig_pos_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_trace_ram (
      .clk_i   (clk),
      .we_i    (we),
      .waddr_i (wr_ptr_q),
      .wdata_i (entry_wdata),
      .re_i    (re),
      .raddr_i (raddr),
      .rdata_o (ram_rdata)
   );

   // RAM read register has no reset; gate data so idle/reset output is zero.
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_valid_q ? ram_rdata : '0;
   assign rd_last   = rd_valid_q && (rd_cnt_q == ONE);
   assign armed     = (state_q == ST_ARMED);
   assign triggered = (state_q == ST_POST) || (state_q == ST_DONE);
   assign done      = (state_q == ST_DONE);
   assign trig_pos  = trig_pos_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
module tb_pipe_trace_buffer;

   localparam int unsigned DEPTH  = 8;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned AW     = 3;
   localparam int unsigned EW     = 2 * DATA_W + 7;

   logic              clk = 1'b0;
   logic              reset, arm, abort, sample_en, start_read, rd_ready;
   logic [DATA_W-1:0] PC_in, WB_WriteData, trig_value;
   logic              WB_RegWrite, Stall_flush;
   logic [4:0]        WB_WriteRegister;
   logic [1:0]        trig_mode;
   logic [AW:0]       post_count;
   logic              rd_valid, rd_last, armed, triggered, done;
   logic [EW-1:0]     rd_data;
   logic [AW-1:0]     trig_pos;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   pipe_trace_buffer #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .arm              (arm),
      .abort            (abort),
      .sample_en        (sample_en),
      .PC_in            (PC_in),
      .WB_RegWrite      (WB_RegWrite),
      .WB_WriteRegister (WB_WriteRegister),
      .WB_WriteData     (WB_WriteData),
      .Stall_flush      (Stall_flush),
      .trig_mode        (trig_mode),
      .trig_value       (trig_value),
      .post_count       (post_count),
      .start_read       (start_read),
      .rd_ready         (rd_ready),
      .rd_valid         (rd_valid),
      .rd_data          (rd_data),
      .rd_last          (rd_last),
      .armed            (armed),
      .triggered        (triggered),
      .done             (done),
      .trig_pos         (trig_pos)
   );

   function automatic logic [EW-1:0] mk_entry(input logic st, input logic rw,
                                              input logic [4:0] wr, input logic [31:0] pc);
      return {st, rw, wr, pc, pc ^ 32'h5A5A_0000};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_sample(input logic en, input logic [31:0] pc, input logic rw,
                             input logic [4:0] wr, input logic st);
      sample_en        = en;
      PC_in            = pc;
      WB_WriteData     = pc ^ 32'h5A5A_0000;
      WB_RegWrite      = rw;
      WB_WriteRegister = wr;
      Stall_flush      = st;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   task automatic pulse_start();
      sample_en  = 1'b0;
      start_read = 1'b1;
      step();
      start_read = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; arm = 1'b0; abort = 1'b0; start_read = 1'b0; rd_ready = 1'b0;
      trig_mode = 2'd0; trig_value = '0; post_count = '0;
      set_sample(1'b1, 32'h40, 1'b1, 5'd1, 1'b0);
      repeat (3) step();
      tests_run++;
      if ({rd_valid, armed, triggered, done, rd_last} !== 5'b0 || trig_pos !== 3'd0 || rd_data !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got v=%b a=%b t=%b d=%b l=%b pos=%0d data=%h, want all 0",
                  rd_valid, armed, triggered, done, rd_last, trig_pos, rd_data);
      end
      reset = 1'b0;
      repeat (2) step();
      tests_run++;
      if (armed !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_after_reset: got a=%b d=%b v=%b, want 0 0 0", armed, done, rd_valid);
      end
   endtask

   task automatic test_wrap_trigger();
      int  last_i = -1;
      logic [EW-1:0] exp;
      trig_mode = 2'd1; trig_value = 32'h20; post_count = 4'd2;
      pulse_arm();
      tests_run++;
      if (armed !== 1'b1) begin
         tests_failed++;
         $display("FAIL wrap_armed: got %b want 1", armed);
      end
      for (int i = 0; i < 16; i++) begin
         set_sample(1'b1, 32'(i * 4), 1'b0, 5'(i), 1'b0);
         step();
         if (i == 8) begin
            tests_run++;
            if (triggered !== 1'b1 || armed !== 1'b0) begin
               tests_failed++;
               $display("FAIL wrap_triggered: got t=%b a=%b want t=1 a=0", triggered, armed);
            end
         end
         if (done === 1'b1) begin
            last_i = i;
            break;
         end
      end
      tests_run++;
      if (last_i !== 10) begin
         tests_failed++;
         $display("FAIL wrap_done_point: done after sample %0d, want 10 (PC 0x28)", last_i);
      end
      // Buffer must stay frozen while done.
      set_sample(1'b1, 32'h2C, 1'b0, 5'd11, 1'b0); step();
      set_sample(1'b1, 32'h30, 1'b0, 5'd12, 1'b0); step();
      tests_run++;
      if (trig_pos !== 3'd5 || done !== 1'b1) begin
         tests_failed++;
         $display("FAIL wrap_trig_pos: got pos=%0d done=%b want pos=5 done=1", trig_pos, done);
      end
      pulse_start();
      rd_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp = mk_entry(1'b0, 1'b0, 5'(3 + k), 32'(12 + 4 * k));
         tests_run++;
         if (rd_valid !== 1'b1 || rd_data !== exp || rd_last !== (k == 7)) begin
            tests_failed++;
            $display("FAIL wrap_entry%0d: got v=%b last=%b data=%h want v=1 last=%b data=%h",
                     k, rd_valid, rd_last, rd_data, (k == 7), exp);
         end
         step();
      end
      tests_run++;
      if (rd_valid !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL wrap_end_idle: got v=%b d=%b want 0 0", rd_valid, done);
      end
      rd_ready = 1'b0;
   endtask

   task automatic test_immediate();
      logic [EW-1:0] exp;
      trig_mode = 2'd0; post_count = 4'd2;
      pulse_arm();
      for (int i = 0; i < 3; i++) begin
         set_sample(1'b1, 32'(32'h100 + 4 * i), 1'b0, 5'd0, 1'b0);
         step();
      end
      set_sample(1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
      tests_run++;
      if (done !== 1'b1 || trig_pos !== 3'd0) begin
         tests_failed++;
         $display("FAIL imm_done: got d=%b pos=%0d want d=1 pos=0", done, trig_pos);
      end
      pulse_start();
      rd_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp = mk_entry(1'b0, 1'b0, 5'd0, 32'(32'h100 + 4 * k));
         tests_run++;
         if (rd_valid !== 1'b1 || rd_data !== exp || rd_last !== (k == 2)) begin
            tests_failed++;
            $display("FAIL imm_entry%0d: got v=%b last=%b data=%h want v=1 last=%b data=%h",
                     k, rd_valid, rd_last, rd_data, (k == 2), exp);
         end
         step();
      end
      tests_run++;
      if (rd_valid !== 1'b0 || done !== 1'b0 || armed !== 1'b0) begin
         tests_failed++;
         $display("FAIL imm_end_idle: got v=%b d=%b a=%b want 0 0 0", rd_valid, done, armed);
      end
      rd_ready = 1'b0;
   endtask

   task automatic test_ready_pattern();
      logic [4:0]    pat = 5'b11001;   // cycle 0..4 -> 1,0,0,1,1
      logic          rdy;
      int            e = 0;
      logic [EW-1:0] exp;
      trig_mode = 2'd0; post_count = 4'd4;
      pulse_arm();
      for (int i = 0; i < 5; i++) begin
         set_sample(1'b1, 32'(32'h200 + 4 * i), 1'b1, 5'(i), 1'b1);
         step();
      end
      pulse_start();
      for (int c = 0; c < 20 && rd_valid === 1'b1; c++) begin
         rdy = (c < 5) ? pat[c] : 1'b1;
         exp = mk_entry(1'b1, 1'b1, 5'(e), 32'(32'h200 + 4 * e));
         tests_run++;
         if (rd_data !== exp || rd_last !== (e == 4)) begin
            tests_failed++;
            $display("FAIL ready_cycle%0d: got last=%b data=%h want last=%b data=%h",
                     c, rd_last, rd_data, (e == 4), exp);
         end
         rd_ready = rdy;
         step();
         if (rdy) e++;
      end
      tests_run++;
      if (e !== 5 || rd_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL ready_count: got %0d transfers v=%b want 5 v=0", e, rd_valid);
      end
      rd_ready = 1'b0;
   endtask

   task automatic test_wreg_trigger();
      logic [EW-1:0] exp [4];
      exp[0] = mk_entry(1'b0, 1'b0, 5'd5, 32'h300);
      exp[1] = mk_entry(1'b0, 1'b1, 5'd3, 32'h308);
      exp[2] = mk_entry(1'b0, 1'b1, 5'd5, 32'h30C);
      exp[3] = mk_entry(1'b0, 1'b0, 5'd0, 32'h314);
      trig_mode = 2'd2; trig_value = 32'h5; post_count = 4'd1;
      pulse_arm();
      set_sample(1'b1, 32'h300, 1'b0, 5'd5, 1'b0); step();
      set_sample(1'b0, 32'h304, 1'b1, 5'd5, 1'b0); step();
      tests_run++;
      if (triggered !== 1'b0 || armed !== 1'b1) begin
         tests_failed++;
         $display("FAIL wreg_no_trig: got t=%b a=%b want t=0 a=1", triggered, armed);
      end
      set_sample(1'b1, 32'h308, 1'b1, 5'd3, 1'b0); step();
      set_sample(1'b1, 32'h30C, 1'b1, 5'd5, 1'b0); step();
      tests_run++;
      if (triggered !== 1'b1 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL wreg_trig: got t=%b d=%b want t=1 d=0", triggered, done);
      end
      set_sample(1'b0, 32'h310, 1'b0, 5'd0, 1'b0); step();
      tests_run++;
      if (done !== 1'b0) begin
         tests_failed++;
         $display("FAIL wreg_gap: got d=%b want 0", done);
      end
      set_sample(1'b1, 32'h314, 1'b0, 5'd0, 1'b0); step();
      tests_run++;
      if (done !== 1'b1 || trig_pos !== 3'd2) begin
         tests_failed++;
         $display("FAIL wreg_done: got d=%b pos=%0d want d=1 pos=2", done, trig_pos);
      end
      pulse_start();
      rd_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (rd_valid !== 1'b1 || rd_data !== exp[k] || rd_last !== (k == 3)) begin
            tests_failed++;
            $display("FAIL wreg_entry%0d: got v=%b last=%b data=%h want v=1 last=%b data=%h",
                     k, rd_valid, rd_last, rd_data, (k == 3), exp[k]);
         end
         step();
      end
      rd_ready = 1'b0;
   endtask

   task automatic test_clamp();
      trig_mode = 2'd0; post_count = 4'd12;   // clamps to 7
      pulse_arm();
      for (int i = 0; i < 7; i++) begin
         set_sample(1'b1, 32'(32'h400 + 4 * i), 1'b0, 5'd0, 1'b0);
         step();
      end
      tests_run++;
      if (done !== 1'b0 || triggered !== 1'b1) begin
         tests_failed++;
         $display("FAIL clamp_not_done: got d=%b t=%b want d=0 t=1", done, triggered);
      end
      set_sample(1'b1, 32'h41C, 1'b0, 5'd0, 1'b0); step();
      tests_run++;
      if (done !== 1'b1 || trig_pos !== 3'd0) begin
         tests_failed++;
         $display("FAIL clamp_done: got d=%b pos=%0d want d=1 pos=0", done, trig_pos);
      end
      pulse_start();
      tests_run++;
      if (rd_valid !== 1'b1 || rd_data !== mk_entry(1'b0, 1'b0, 5'd0, 32'h400)) begin
         tests_failed++;
         $display("FAIL clamp_first: got v=%b data=%h want v=1 data=%h",
                  rd_valid, rd_data, mk_entry(1'b0, 1'b0, 5'd0, 32'h400));
      end
      abort = 1'b1; step(); abort = 1'b0;
      tests_run++;
      if (rd_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_readout: got v=%b want 0", rd_valid);
      end
   endtask

   task automatic test_abort();
      trig_mode = 2'd0; post_count = 4'd3;
      pulse_arm();
      set_sample(1'b1, 32'h500, 1'b0, 5'd0, 1'b0); step();
      set_sample(1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
      tests_run++;
      if (triggered !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_in_post_setup: got t=%b want 1", triggered);
      end
      abort = 1'b1; step(); abort = 1'b0;
      tests_run++;
      if (triggered !== 1'b0 || done !== 1'b0 || armed !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_post: got t=%b d=%b a=%b want 0 0 0", triggered, done, armed);
      end
      arm = 1'b1; abort = 1'b1; step(); arm = 1'b0; abort = 1'b0;
      tests_run++;
      if (armed !== 1'b0) begin
         tests_failed++;
         $display("FAIL arm_abort_same: got a=%b want 0", armed);
      end
      post_count = 4'd0;
      pulse_arm();
      set_sample(1'b1, 32'h600, 1'b0, 5'd0, 1'b0); step();
      pulse_start();
      tests_run++;
      if (rd_valid !== 1'b1 || rd_last !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_mid_setup: got v=%b last=%b want 1 1", rd_valid, rd_last);
      end
      reset = 1'b1;
      #1;
      tests_run++;
      if (rd_valid !== 1'b0 || rd_data !== '0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_readout: got v=%b d=%b data=%h want 0 0 0", rd_valid, done, rd_data);
      end
      step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_wrap_trigger();
      test_immediate();
      test_ready_pattern();
      test_wreg_trigger();
      test_clamp();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
